// File: rtl/spin_credit_controller.sv
// spin_credit_controller
//   Sequences one play of the slot machine and owns the credit balance.
//   IDLE -> SPINNING (reels running) -> LOOKUP (one cycle, payout x bet)
//   -> PAYING (one credit per tick, spin_btn fast-forwards) -> IDLE.
//
// Ports
//   clk, rst_n        : clock, async active-low reset
//   coin              : pulse, +1 credit in any state
//   bet_btn           : pulse, bet 1..MAX_BET wrap (IDLE only)
//   spin_btn          : pulse, start spin (IDLE) / fast-forward (PAYING)
//   tick              : pulse, payout count rate
//   reels_done        : pulse, reel_symbols valid this cycle
//   reel_symbols[8:0] : {reel2, reel1, reel0}
//   payout[15:0]      : payout table result for lookup_symbols
//   lookup_symbols    : latched symbols driving the payout table
//   spin_start        : one-cycle pulse to the reel animator
//   credits, bet, win : balance, current bet, last win
//   busy, state       : not-IDLE flag, FSM state for the overlay
module spin_credit_controller #(
  parameter int CREDIT_W      = 16,
  parameter int MAX_BET       = 3,
  parameter int START_CREDITS = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin,
  input  logic                bet_btn,
  input  logic                spin_btn,
  input  logic                tick,
  input  logic                reels_done,
  input  logic [8:0]          reel_symbols,
  input  logic [15:0]         payout,
  output logic [8:0]          lookup_symbols,
  output logic                spin_start,
  output logic [CREDIT_W-1:0] credits,
  output logic [1:0]          bet,
  output logic [CREDIT_W-1:0] win,
  output logic                busy,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPINNING = 2'd1, LOOKUP = 2'd2, PAYING = 2'd3} st_e;

  localparam logic [1:0]          MAXB   = 2'(MAX_BET);
  localparam logic [CREDIT_W-1:0] CR_MAX = {CREDIT_W{1'b1}};
  localparam logic [CREDIT_W+1:0] SUM_MAX = {2'b00, CR_MAX};

  st_e                 st, st_nx;
  logic [CREDIT_W-1:0] rem, rem_nx;
  logic [CREDIT_W-1:0] credits_nx, win_nx;
  logic [1:0]          bet_nx;
  logic [8:0]          sym_nx;
  logic                start_nx;

  // Credit delta for this cycle: all increments (coin, tick, fast-forward)
  // and the spin deduction are folded into one saturating update so that
  // coin collisions with FSM activity simply add up.
  logic [CREDIT_W+1:0] add, sub, sum;

  // Payout scaled by bet; 18 bits holds 65535 x 3 without overflow.
  logic [17:0]         prod;
  logic [CREDIT_W-1:0] prod_sat;

  assign prod = 18'(payout) * 18'(bet);

  always_comb begin
    prod_sat = CREDIT_W'(prod);
    if (CREDIT_W < 18 && (prod >> CREDIT_W) != '0) prod_sat = CR_MAX;
  end

  always_comb begin
    st_nx    = st;
    bet_nx   = bet;
    win_nx   = win;
    sym_nx   = lookup_symbols;
    rem_nx   = rem;
    start_nx = 1'b0;
    add      = {{(CREDIT_W+1){1'b0}}, coin};
    sub      = '0;
    case (st)
      IDLE: begin
        if (bet_btn) bet_nx = (bet == MAXB) ? 2'd1 : bet + 2'd1;
        // Spin uses the pre-advance bet when both buttons land together.
        if (spin_btn && credits >= {{(CREDIT_W-2){1'b0}}, bet}) begin
          sub      = {{CREDIT_W{1'b0}}, bet};
          win_nx   = '0;
          start_nx = 1'b1;
          st_nx    = SPINNING;
        end
      end
      SPINNING: begin
        if (reels_done) begin
          sym_nx = reel_symbols;
          st_nx  = LOOKUP;
        end
      end
      LOOKUP: begin
        win_nx = prod_sat;
        if (prod_sat == '0) begin
          st_nx = IDLE;
        end else begin
          rem_nx = prod_sat;
          st_nx  = PAYING;
        end
      end
      PAYING: begin
        // Fast-forward takes precedence over a same-cycle tick.
        if (spin_btn) begin
          add    = add + {2'b00, rem};
          rem_nx = '0;
          st_nx  = IDLE;
        end else if (tick) begin
          add    = add + {{(CREDIT_W+1){1'b0}}, 1'b1};
          rem_nx = rem - 1'b1;
          if (rem == {{(CREDIT_W-1){1'b0}}, 1'b1}) st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
    // Deduction only happens when credits >= bet, so sum never underflows.
    sum        = {2'b00, credits} + add - sub;
    credits_nx = (sum > SUM_MAX) ? CR_MAX : sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      credits        <= CREDIT_W'(START_CREDITS);
      bet            <= 2'd1;
      win            <= '0;
      lookup_symbols <= '0;
      rem            <= '0;
      spin_start     <= 1'b0;
    end else begin
      st             <= st_nx;
      credits        <= credits_nx;
      bet            <= bet_nx;
      win            <= win_nx;
      lookup_symbols <= sym_nx;
      rem            <= rem_nx;
      spin_start     <= start_nx;
    end
  end

  assign busy  = (st != IDLE);
  assign state = st;

endmodule
